// File: rtl/pps_sync_pkg.sv
// Shared types and helpers for the PPS sync controller: state encodings,
// half-millisecond period derivation and the PPS accept-window compare.
package pps_sync_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_PPS = 3'd1,
      ST_TRACK    = 3'd2,
      ST_LOCKED   = 3'd3,
      ST_HOLDOVER = 3'd4,
      ST_RESYNC   = 3'd5
   } state_e;

   function automatic int unsigned half_ms(input int unsigned freq);
      return freq / 32'd2000;
   endfunction

   function automatic logic in_window(input logic [31:0] cnt,
                                      input logic [31:0] freq,
                                      input logic [31:0] tol);
      return (cnt <= tol) || (cnt >= (freq - tol));
   endfunction

   // States in which the second/half-ms counters run and the frame-sync block is enabled.
   function automatic logic is_synced(input state_e s);
      return (s == ST_TRACK) || (s == ST_LOCKED) || (s == ST_HOLDOVER);
   endfunction

endpackage

// File: rtl/pps_sync_ctrl_edge_det.sv
// Rising-edge detector for the (already synchronous) 1PPS level.
module pps_sync_ctrl_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic pps_in,
   output logic pps_rise
);

   logic pps_dly_q;
   logic pps_dly_d;

   // Next value of the delayed PPS sample.
   always_comb begin
      pps_dly_d = pps_in;
   end

   // Delayed PPS sample register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pps_dly_q <= 1'b0;
      end else begin
         pps_dly_q <= pps_dly_d;
      end
   end

   assign pps_rise = pps_in & ~pps_dly_q;

endmodule

// File: rtl/pps_sync_ctrl.sv
// PPS sync controller: acquires the 1PPS reference, qualifies later edges against a
// free-running one-second counter, tracks lock/holdover and drives the frame-sync block.
module pps_sync_ctrl
   import pps_sync_pkg::*;
#(
   parameter int unsigned FREQ     = 32'd30720000,
   parameter int unsigned PPS_TOL  = 32'd8,
   parameter int unsigned LOCK_CNT = 32'd3,
   parameter int unsigned LOSS_CNT = 32'd2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               pps_in,
   input  logic               force_resync,
   input  logic               irq_en,
   input  logic               err_clr,
   output logic               pps_start,
   output logic               sync_enable,
   output logic               irq_half_ms,
   output logic               locked,
   output logic [2:0]         state,
   output logic signed [31:0] pps_offset,
   output logic [15:0]        pps_err_cnt
);

   localparam int unsigned HALF_MS   = half_ms(FREQ);
   localparam int unsigned HALF_W    = (HALF_MS > 32'd1) ? $clog2(HALF_MS) : 32'd1;
   localparam logic [31:0] SEC_LAST  = 32'(FREQ - 32'd1);
   localparam logic [31:0] SEC_HALF  = 32'(FREQ / 32'd2);
   localparam logic [31:0] WIN_OPEN  = 32'(FREQ - PPS_TOL);
   localparam logic [31:0] WIN_CLOSE = 32'(PPS_TOL + 32'd1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_MS - 32'd1);
   localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(32'd1);

   state_e             state_q, state_d;
   logic [31:0]        sec_cnt_q, sec_cnt_d;
   logic [HALF_W-1:0]  half_cnt_q, half_cnt_d;
   logic [7:0]         good_cnt_q, good_cnt_d;
   logic [7:0]         miss_cnt_q, miss_cnt_d;
   logic               edge_seen_q, edge_seen_d;
   logic               pps_start_q, pps_start_d;
   logic               sync_enable_q, sync_enable_d;
   logic               irq_q, irq_d;
   logic               locked_q, locked_d;
   logic signed [31:0] offset_q, offset_d;
   logic [15:0]        err_cnt_q, err_cnt_d;

   logic               pps_rise;
   logic               run_cnt;
   logic               in_win;
   logic               miss_now;
   logic               err_inc;
   logic signed [31:0] offset_now;

   pps_sync_ctrl_edge_det u_edge_det (
      .clk      (clk),
      .rst_n    (rst_n),
      .pps_in   (pps_in),
      .pps_rise (pps_rise)
   );

   assign run_cnt    = is_synced(state_q);
   assign in_win     = in_window(sec_cnt_q, 32'(FREQ), 32'(PPS_TOL));
   assign offset_now = (sec_cnt_q < SEC_HALF) ? $signed(sec_cnt_q) : $signed(sec_cnt_q - 32'(FREQ));
   // An edge landing on the window-close cycle is judged bad, so it suppresses the miss.
   assign miss_now   = run_cnt && (sec_cnt_q == WIN_CLOSE) && !edge_seen_q && !pps_rise;

   // Next-state, counter and output computation.
   always_comb begin
      state_d     = state_q;
      sec_cnt_d   = sec_cnt_q;
      half_cnt_d  = half_cnt_q;
      good_cnt_d  = good_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      edge_seen_d = edge_seen_q;
      offset_d    = offset_q;
      pps_start_d = 1'b0;
      err_inc     = 1'b0;

      if (run_cnt) begin
         sec_cnt_d   = (sec_cnt_q == SEC_LAST) ? 32'd0 : sec_cnt_q + 32'd1;
         half_cnt_d  = (half_cnt_q == HALF_LAST) ? '0 : half_cnt_q + HALF_ONE;
         edge_seen_d = (sec_cnt_q == WIN_OPEN) ? 1'b0 : edge_seen_q;
      end else begin
         sec_cnt_d   = sec_cnt_q;
      end
      if (pps_rise) begin
         edge_seen_d = 1'b1;
      end else begin
         edge_seen_d = edge_seen_d;
      end

      if (!enable) begin
         state_d = ST_IDLE;
      end else if (force_resync && (state_q != ST_IDLE)) begin
         state_d = ST_RESYNC;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_PPS;
            end
            ST_WAIT_PPS: begin
               if (pps_rise) begin
                  state_d     = ST_TRACK;
                  pps_start_d = 1'b1;
                  sec_cnt_d   = 32'd1;
                  half_cnt_d  = HALF_ONE;
                  good_cnt_d  = 8'd1;
                  miss_cnt_d  = 8'd0;
               end else begin
                  state_d = ST_WAIT_PPS;
               end
            end
            ST_TRACK, ST_LOCKED, ST_HOLDOVER: begin
               if (pps_rise) begin
                  offset_d = offset_now;
                  if (in_win) begin
                     sec_cnt_d  = 32'd1;
                     half_cnt_d = HALF_ONE;
                     miss_cnt_d = 8'd0;
                     if (state_q == ST_HOLDOVER) begin
                        state_d    = ST_TRACK;
                        good_cnt_d = 8'd1;
                     end else if (state_q == ST_TRACK) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        state_d    = ((good_cnt_q + 8'd1) >= 8'(LOCK_CNT)) ? ST_LOCKED : ST_TRACK;
                     end else begin
                        state_d = ST_LOCKED;
                     end
                  end else begin
                     state_d = ST_RESYNC;
                     err_inc = 1'b1;
                  end
               end else if (miss_now && (state_q != ST_HOLDOVER)) begin
                  err_inc = 1'b1;
                  if (state_q == ST_TRACK) begin
                     state_d = ST_RESYNC;
                  end else begin
                     miss_cnt_d = miss_cnt_q + 8'd1;
                     state_d    = ((miss_cnt_q + 8'd1) >= 8'(LOSS_CNT)) ? ST_HOLDOVER : ST_LOCKED;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_RESYNC: begin
               if (pps_rise) begin
                  offset_d = offset_now;
               end else begin
                  offset_d = offset_q;
               end
               state_d = ST_WAIT_PPS;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Counters only hold meaningful values while synced; everywhere else they sit at zero.
      if (!is_synced(state_d)) begin
         sec_cnt_d   = 32'd0;
         half_cnt_d  = '0;
         good_cnt_d  = 8'd0;
         miss_cnt_d  = 8'd0;
         edge_seen_d = 1'b0;
      end else begin
         good_cnt_d  = good_cnt_d;
      end

      if (err_clr) begin
         err_cnt_d = 16'd0;
      end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end

      sync_enable_d = is_synced(state_d);
      locked_d      = (state_d == ST_LOCKED);
      irq_d         = irq_en && run_cnt && (half_cnt_q == HALF_LAST);
   end

   // State, counter and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         sec_cnt_q     <= 32'd0;
         half_cnt_q    <= '0;
         good_cnt_q    <= 8'd0;
         miss_cnt_q    <= 8'd0;
         edge_seen_q   <= 1'b0;
         pps_start_q   <= 1'b0;
         sync_enable_q <= 1'b0;
         irq_q         <= 1'b0;
         locked_q      <= 1'b0;
         offset_q      <= 32'sd0;
         err_cnt_q     <= 16'd0;
      end else begin
         state_q       <= state_d;
         sec_cnt_q     <= sec_cnt_d;
         half_cnt_q    <= half_cnt_d;
         good_cnt_q    <= good_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         edge_seen_q   <= edge_seen_d;
         pps_start_q   <= pps_start_d;
         sync_enable_q <= sync_enable_d;
         irq_q         <= irq_d;
         locked_q      <= locked_d;
         offset_q      <= offset_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign pps_start   = pps_start_q;
   assign sync_enable = sync_enable_q;
   assign irq_half_ms = irq_q;
   assign locked      = locked_q;
   assign state       = state_q;
   assign pps_offset  = offset_q;
   assign pps_err_cnt = err_cnt_q;

endmodule
